rf_wb_arbiter: RTL and testbench



---
 rtl/rf_arb_pkg.sv | 28 ++
 rtl/rf_wb_slot.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// ============================================================================
//  Module   : rf_arb_pkg
//  Purpose  : Shared defaults, requester indices and counter helper for the
//             register-file writeback arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;
    localparam int DEF_CW = 2;

    // Requester indices; the grant flag stores the index of the last winner.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    // Largest value a cw-bit outstanding-write counter can hold.
    function automatic int cnt_max_of(input int cw);
        return (1 << cw) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max_of(DEF_CW);

endpackage

`default_nettype wire

// File: rtl/rf_wb_slot.sv
// ============================================================================
//  Module   : rf_wb_slot
//  Purpose  : One-entry valid/ready holding register for a writeback
//             requester. Loads on vld && rdy, empties on drain.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_slot #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld,
    input  logic [AW-1:0] in_idx,
    input  logic [DW-1:0] in_dat,
    input  logic          drain,
    output logic          rdy,
    output logic          full,
    output logic [AW-1:0] slot_idx,
    output logic [DW-1:0] slot_dat
);

    // A slot is ready exactly when it is empty, so it never loads and
    // drains in the same cycle.
    assign rdy = !full;

    // Capture on a handshake, release when the arbiter drains the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            slot_idx <= '0;
            slot_dat <= '0;
        end else if (vld && !full) begin
            full     <= 1'b1;
            slot_idx <= in_idx;
            slot_dat <= in_dat;
        end else if (drain) begin
            full     <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Shares the register file write port between the ALU and load
//             writeback paths (round-robin), and keeps a per-register count
//             of outstanding writes for RAW hazard detection on three read
//             ports.
//  Options  : RF_WB_FWD_EN - adds fwdA/fwdB/fwdC forwarding of the winning
//             slot data and suppresses the matching hazard for that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
) (
    input  logic          btn,
    input  logic          Rst,
    input  logic          alu_vld,
    output logic          alu_rdy,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_dat,
    input  logic          mem_vld,
    output logic          mem_rdy,
    input  logic [AW-1:0] mem_reg,
    input  logic [DW-1:0] mem_dat,
    input  logic          iss_vld,
    output logic          iss_rdy,
    input  logic [AW-1:0] iss_reg,
    input  logic [AW-1:0] qA,
    input  logic [AW-1:0] qB,
    input  logic [AW-1:0] qC,
    output logic          hzA,
    output logic          hzB,
    output logic          hzC,
    output logic [AW-1:0] regW,
    output logic [DW-1:0] Wdat,
    output logic          RegWrite,
    output logic          gnt_mem
`ifdef RF_WB_FWD_EN
    ,
    output logic [DW-1:0] fwdA,
    output logic [DW-1:0] fwdB,
    output logic [DW-1:0] fwdC
`endif
);

    localparam int            NREG    = 1 << AW;
    localparam logic [CW-1:0] CNT_TOP = CW'(cnt_max_of(CW));

    logic          alu_full, mem_full;
    logic [AW-1:0] alu_sidx, mem_sidx;
    logic [DW-1:0] alu_sdat, mem_sdat;
    logic          alu_drain, mem_drain;

    logic          win_any;
    logic          win_sel;
    logic [AW-1:0] win_reg;
    logic [DW-1:0] win_dat;
    logic          commit;
    logic          iss_fire;

    // Per-register status flags; bit 0 (r0) is permanently clear.
    logic [NREG-1:0] cnt_nz;
    logic [NREG-1:0] cnt_full;

    rf_wb_slot #(.DW(DW), .AW(AW)) u_alu_slot (
        .clk      (btn),
        .rst      (Rst),
        .vld      (alu_vld),
        .in_idx   (alu_reg),
        .in_dat   (alu_dat),
        .drain    (alu_drain),
        .rdy      (alu_rdy),
        .full     (alu_full),
        .slot_idx (alu_sidx),
        .slot_dat (alu_sdat)
    );

    rf_wb_slot #(.DW(DW), .AW(AW)) u_mem_slot (
        .clk      (btn),
        .rst      (Rst),
        .vld      (mem_vld),
        .in_idx   (mem_reg),
        .in_dat   (mem_dat),
        .drain    (mem_drain),
        .rdy      (mem_rdy),
        .full     (mem_full),
        .slot_idx (mem_sidx),
        .slot_dat (mem_sdat)
    );

    // Round-robin pick over full slots: on a tie, whoever did not win last.
    always_comb begin
        win_any = alu_full || mem_full;
        if (alu_full && mem_full) begin
            win_sel = (gnt_mem == REQ_MEM) ? REQ_ALU : REQ_MEM;
        end else begin
            win_sel = mem_full ? REQ_MEM : REQ_ALU;
        end
        win_reg = (win_sel == REQ_MEM) ? mem_sidx : alu_sidx;
        win_dat = (win_sel == REQ_MEM) ? mem_sdat : alu_sdat;
    end

    assign alu_drain = win_any && (win_sel == REQ_ALU);
    assign mem_drain = win_any && (win_sel == REQ_MEM);

    // r0 drains empty the slot but never reach the register file.
    assign commit   = win_any && (win_reg != '0);
    assign iss_rdy  = !cnt_full[iss_reg];
    assign iss_fire = iss_vld && iss_rdy && (iss_reg != '0);

    assign cnt_nz[0]   = 1'b0;
    assign cnt_full[0] = 1'b0;

`ifdef RF_WB_FWD_EN
    logic [NREG-1:0] cnt_one;
    assign cnt_one[0] = 1'b0;
`endif

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic [CW-1:0] count;
        logic          inc;
        logic          dec;

        assign inc = iss_fire && (iss_reg == AW'(i));
        assign dec = commit && (win_reg == AW'(i));

        // Outstanding-write counter; simultaneous inc/dec cancel, and a
        // stray decrement at zero is absorbed.
        always_ff @(posedge btn or posedge Rst) begin
            if (Rst) begin
                count <= '0;
            end else if (inc && !dec) begin
                count <= count + CW'(1);
            end else if (dec && !inc && (count != '0)) begin
                count <= count - CW'(1);
            end
        end

        assign cnt_nz[i]   = (count != '0);
        assign cnt_full[i] = (count == CNT_TOP);
`ifdef RF_WB_FWD_EN
        assign cnt_one[i]  = (count == CW'(1));
`endif
    end

`ifdef RF_WB_FWD_EN
    logic hitA, hitB, hitC;

    // The last outstanding write to a queried register is on the write port
    // right now and nothing new is being issued to it: hand the data over.
    assign hitA = win_any && (qA != '0) && (win_reg == qA) && cnt_one[qA]
                  && !(iss_fire && (iss_reg == qA));
    assign hitB = win_any && (qB != '0) && (win_reg == qB) && cnt_one[qB]
                  && !(iss_fire && (iss_reg == qB));
    assign hitC = win_any && (qC != '0) && (win_reg == qC) && cnt_one[qC]
                  && !(iss_fire && (iss_reg == qC));

    assign hzA  = cnt_nz[qA] && !hitA;
    assign hzB  = cnt_nz[qB] && !hitB;
    assign hzC  = cnt_nz[qC] && !hitC;
    assign fwdA = hitA ? win_dat : '0;
    assign fwdB = hitB ? win_dat : '0;
    assign fwdC = hitC ? win_dat : '0;
`else
    assign hzA = cnt_nz[qA];
    assign hzB = cnt_nz[qB];
    assign hzC = cnt_nz[qC];
`endif

    // Registered write command and grant history.
    always_ff @(posedge btn or posedge Rst) begin
        if (Rst) begin
            RegWrite <= 1'b0;
            regW     <= '0;
            Wdat     <= '0;
            gnt_mem  <= REQ_MEM;
        end else begin
            RegWrite <= commit;
            if (commit) begin
                regW <= win_reg;
                Wdat <= win_dat;
            end
            if (win_any) begin
                gnt_mem <= win_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Purpose  : Self-checking bench for rf_wb_arbiter: directed scenarios plus
//             random traffic against a behavioural model.
//  Options  : RF_WB_FWD_EN - also checks the forwarding outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rf_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          btn = 1'b0;
    logic          Rst = 1'b1;
    logic          alu_vld, mem_vld, iss_vld;
    logic [AW-1:0] alu_reg, mem_reg, iss_reg, qA, qB, qC;
    logic [DW-1:0] alu_dat, mem_dat;
    logic          alu_rdy, mem_rdy, iss_rdy, hzA, hzB, hzC, RegWrite, gnt_mem;
    logic [AW-1:0] regW;
    logic [DW-1:0] Wdat;
`ifdef RF_WB_FWD_EN
    logic [DW-1:0] fwdA, fwdB, fwdC;
`endif

    always #5 btn = ~btn;

    rf_wb_arbiter #(.DW(DW), .AW(AW), .CW(2)) dut (
        .btn      (btn),
        .Rst      (Rst),
        .alu_vld  (alu_vld),
        .alu_rdy  (alu_rdy),
        .alu_reg  (alu_reg),
        .alu_dat  (alu_dat),
        .mem_vld  (mem_vld),
        .mem_rdy  (mem_rdy),
        .mem_reg  (mem_reg),
        .mem_dat  (mem_dat),
        .iss_vld  (iss_vld),
        .iss_rdy  (iss_rdy),
        .iss_reg  (iss_reg),
        .qA       (qA),
        .qB       (qB),
        .qC       (qC),
        .hzA      (hzA),
        .hzB      (hzB),
        .hzC      (hzC),
        .regW     (regW),
        .Wdat     (Wdat),
        .RegWrite (RegWrite),
        .gnt_mem  (gnt_mem)
`ifdef RF_WB_FWD_EN
        ,
        .fwdA     (fwdA),
        .fwdB     (fwdB),
        .fwdC     (fwdC)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_afull, m_mfull, m_last_mem, e_we, strict;
    int        m_areg, m_mreg, e_regw;
    logic [31:0] m_adat, m_mdat, e_wdat;
    int        cnt_m [NREG];
    int        tok   [NREG];

    task automatic model_reset();
        m_afull = 0; m_mfull = 0; m_last_mem = 1;
        m_areg = 0; m_mreg = 0; m_adat = 0; m_mdat = 0;
        e_we = 0; e_regw = 0; e_wdat = 0;
        for (int i = 0; i < NREG; i++) begin
            cnt_m[i] = 0;
            tok[i]   = 0;
        end
    endtask

    function automatic bit m_iss_ok();
        return (iss_reg == 0) || (cnt_m[iss_reg] < 3);
    endfunction

    // Forwarding applies when the write port is about to retire the only
    // outstanding write of the queried register with no new issue to it.
    function automatic bit m_hit(input int q);
        bit any, wm;
        int wr;
        bit ifire;
`ifdef RF_WB_FWD_EN
        any   = m_afull || m_mfull;
        wm    = m_mfull && (!m_afull || !m_last_mem);
        wr    = wm ? m_mreg : m_areg;
        ifire = iss_vld && m_iss_ok() && (iss_reg != 0);
        return any && (q != 0) && (wr == q) && (cnt_m[q] == 1) && !(ifire && (iss_reg == q));
`else
        any = 0; wm = 0; wr = q; ifire = 0;
        return any && wm && ifire && (wr < 0);
`endif
    endfunction

    function automatic bit m_hz(input int q);
        return (q != 0) && (cnt_m[q] != 0) && !m_hit(q);
    endfunction

    function automatic logic [31:0] m_fwd(input int q);
        return m_hit(q) ? (((m_mfull && (!m_afull || !m_last_mem))) ? m_mdat : m_adat) : 32'h0;
    endfunction

    // Compare every output against the model, then advance one clock.
    task automatic step();
        bit any, wm, a_rdy, m_rdy, ifire;
        int wr;
        logic [31:0] wd;
        #1;
        chk("alu_rdy", alu_rdy, !m_afull);
        chk("mem_rdy", mem_rdy, !m_mfull);
        chk("iss_rdy", iss_rdy, m_iss_ok());
        chk("hzA", hzA, m_hz(qA));
        chk("hzB", hzB, m_hz(qB));
        chk("hzC", hzC, m_hz(qC));
`ifdef RF_WB_FWD_EN
        chk("fwdA", fwdA, m_fwd(qA));
        chk("fwdB", fwdB, m_fwd(qB));
        chk("fwdC", fwdC, m_fwd(qC));
`endif
        chk("RegWrite", RegWrite, e_we);
        chk("regW", regW, e_regw);
        chk("Wdat", Wdat, e_wdat);
        chk("gnt_mem", gnt_mem, m_last_mem);

        any   = m_afull || m_mfull;
        wm    = m_mfull && (!m_afull || !m_last_mem);
        wr    = wm ? m_mreg : m_areg;
        wd    = wm ? m_mdat : m_adat;
        a_rdy = !m_afull;
        m_rdy = !m_mfull;
        ifire = iss_vld && m_iss_ok() && (iss_reg != 0);

        e_we = 0;
        if (any) begin
            if (wr != 0) begin
                e_we = 1; e_regw = wr; e_wdat = wd;
                if (strict) assert (cnt_m[wr] > 0);
            end
            m_last_mem = wm;
            if (wm) m_mfull = 0; else m_afull = 0;
        end
        if (ifire) cnt_m[iss_reg]++;
        if (any && (wr != 0) && (cnt_m[wr] > 0)) cnt_m[wr]--;
        if (alu_vld && a_rdy) begin m_afull = 1; m_areg = alu_reg; m_adat = alu_dat; end
        if (mem_vld && m_rdy) begin m_mfull = 1; m_mreg = mem_reg; m_mdat = mem_dat; end

        @(posedge btn);
        @(negedge btn);
    endtask

    task automatic idle();
        alu_vld = 0; mem_vld = 0; iss_vld = 0;
    endtask

    task automatic do_reset();
        idle();
        Rst = 1;
        @(posedge btn);
        @(negedge btn);
        Rst = 0;
        model_reset();
    endtask

    function automatic int pick_tok();
        int s;
        int r;
        s = $urandom_range(0, 6);
        for (int k = 0; k < 7; k++) begin
            r = 1 + ((s + k) % 7);
            if (tok[r] > 0) return r;
        end
        return 0;
    endfunction

    initial begin
        strict = 0;
        idle();
        alu_reg = 0; mem_reg = 0; iss_reg = 0; alu_dat = 0; mem_dat = 0;
        qA = 0; qB = 0; qC = 0;
        model_reset();

        // Reset state and a single ALU write.
        do_reset();
        #1;
        chk("rst_alu_rdy", alu_rdy, 1'b1);
        chk("rst_mem_rdy", mem_rdy, 1'b1);
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_gnt_mem", gnt_mem, 1'b1);
        alu_vld = 1; alu_reg = 5; alu_dat = 32'hDEADBEEF;
        step();
        alu_vld = 0;
        chk("t1_alu_rdy_low", alu_rdy, 1'b0);
        step();
        chk("t1_we", RegWrite, 1'b1);
        chk("t1_regW", regW, 5);
        chk("t1_Wdat", Wdat, 32'hDEADBEEF);
        step();
        chk("t1_we_off", RegWrite, 1'b0);
        chk("t1_regW_hold", regW, 5);

        // Both slots full: ALU first after reset, then alternate.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            alu_vld = 1; alu_reg = 1; alu_dat = 32'h11;
            mem_vld = 1; mem_reg = 2; mem_dat = 32'h22;
            step();
            idle();
            step();
            chk("t2_first_reg", regW, 1);
            chk("t2_first_gnt", gnt_mem, 1'b0);
            step();
            chk("t2_second_reg", regW, 2);
            chk("t2_second_dat", Wdat, 32'h22);
            chk("t2_second_gnt", gnt_mem, 1'b1);
        end

        // Scoreboard saturation and drain of r7.
        do_reset();
        qA = 7;
        iss_vld = 1; iss_reg = 7;
        repeat (3) step();
        #1;
        chk("t3_iss_full", iss_rdy, 1'b0);
        chk("t3_hz_full", hzA, 1'b1);
        iss_vld = 0;
        for (int n = 1; n <= 3; n++) begin
            alu_vld = 1; alu_reg = 7; alu_dat = 32'h70 + n;
            step();
            alu_vld = 0;
            step();
            chk("t3_iss_rdy", iss_rdy, 1'b1);
            chk("t3_hzA", hzA, n < 3);
        end

        // Same-cycle issue and commit of r3 keeps the count at one.
        do_reset();
        qB = 3;
        iss_vld = 1; iss_reg = 3;
        step();
        iss_vld = 0;
        alu_vld = 1; alu_reg = 3; alu_dat = 32'h33;
        step();
        alu_vld = 0;
        iss_vld = 1; iss_reg = 3;
        #1;
        chk("t4_hzB_pre", hzB, 1'b1);
`ifdef RF_WB_FWD_EN
        chk("t4_no_fwd", fwdB, 32'h0);
`endif
        step();
        iss_vld = 0;
        step();
        chk("t4_hzB_post", hzB, 1'b1);

        // Load to r0 never reaches the register file.
        do_reset();
        qA = 0; qB = 0; qC = 0;
        mem_vld = 1; mem_reg = 0; mem_dat = 32'hFFFFFFFF;
        step();
        mem_vld = 0;
        chk("t5_mem_busy", mem_rdy, 1'b0);
        step();
        chk("t5_no_we", RegWrite, 1'b0);
        chk("t5_mem_rdy", mem_rdy, 1'b1);
        chk("t5_hz_r0", hzA, 1'b0);

        // Reset one cycle after an ALU accept discards the write.
        do_reset();
        qA = 9;
        iss_vld = 1; iss_reg = 9;
        step();
        iss_vld = 0;
        alu_vld = 1; alu_reg = 9; alu_dat = 32'h99;
        step();
        alu_vld = 0;
        Rst = 1;
        #1;
        chk("t6_alu_rdy", alu_rdy, 1'b1);
        chk("t6_mem_rdy", mem_rdy, 1'b1);
        chk("t6_hzA", hzA, 1'b0);
        chk("t6_we", RegWrite, 1'b0);
        model_reset();
        @(posedge btn);
        @(negedge btn);
        Rst = 0;
        step();
        step();
        chk("t6_no_commit", RegWrite, 1'b0);
        chk("t6_regW", regW, 0);

        // Random traffic: writes only target registers with issued tokens.
        do_reset();
        strict = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            r = pick_tok();
            alu_reg = AW'(r);
            alu_dat = $urandom;
            alu_vld = (r != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            if (alu_vld && !m_afull && (r != 0)) tok[r]--;
            r = pick_tok();
            mem_reg = AW'(r);
            mem_dat = $urandom;
            mem_vld = (r != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            if (mem_vld && !m_mfull && (r != 0)) tok[r]--;
            iss_reg = AW'($urandom_range(0, 7));
            iss_vld = $urandom_range(0, 1);
            if (iss_vld && m_iss_ok() && (iss_reg != 0)) tok[iss_reg]++;
            qA = AW'($urandom_range(0, 7));
            qB = AW'($urandom_range(0, 7));
            qC = AW'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
